// File: rtl/b02_sched_if.sv
// b02_sched_if: requester, grant, serial-line and result signals
// shared between the scheduler and its environment.
interface b02_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4,
  parameter int IDW   = 3
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  LINEA;
  logic                  U;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CNTW-1:0]       result;
  logic                  busy;

  modport master (
    output req, data, U,
    input  gnt, LINEA, done, done_id, result, busy
  );

  modport slave (
    input  req, data, U,
    output gnt, LINEA, done, done_id, result, busy
  );
endinterface

// File: rtl/b02_sched.sv
// b02_sched: arbitrates requesters onto one b02 serial detector.
// Define B02_SCHED_RR_EN for round-robin, else fixed priority.
module b02_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int FLUSH = 2,
  parameter int CNTW  = 4,
  parameter int IDW   = 3
) (
  input  logic       clk,
  input  logic       reset,
  b02_sched_if.slave bus
);

  localparam int MAXC = (WIDTH > FLUSH) ? WIDTH : FLUSH;
  localparam int BCW  = $clog2(MAXC) + 1;
  localparam logic [CNTW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic [CNTW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IDW-1:0]   id_q, id_d;
  logic             linea_q, linea_d;
  logic [IDW-1:0]   did_q, did_d;
  logic [CNTW-1:0]  res_q, res_d;
  logic [IDW-1:0]   win;
  logic             any;
  logic [WIDTH-1:0] word;

`ifdef B02_SCHED_RR_EN
  logic [IDW-1:0] ptr_q;

  // Descending scan so the smallest offset from ptr wins.
  always_comb begin
    int idx;
    win = '0;
    any = |bus.req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (bus.req[idx]) win = IDW'(idx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (state_q == S_IDLE && any) begin
      ptr_q <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end
`else
  always_comb begin
    win = '0;
    any = |bus.req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win = IDW'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    linea_d = 1'b0;
    did_d   = did_q;
    res_d   = res_q;
    word    = '0;
    cnt_inc = (cnt_q == CMAX) ? cnt_q
                              : cnt_q + CNTW'(bus.U);
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          word    = bus.data[int'(win)*WIDTH +: WIDTH];
          linea_d = word[WIDTH-1];
          sh_d    = word << 1;
          id_d    = win;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_inc;
        if (bit_q == BCW'(WIDTH - 1)) begin
          bit_d   = '0;
          state_d = S_FLUSH;
        end else begin
          bit_d   = bit_q + 1'b1;
          linea_d = sh_q[WIDTH-1];
          sh_d    = sh_q << 1;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_inc;
        if (bit_q == BCW'(FLUSH - 1)) begin
          state_d = S_DONE;
          res_d   = cnt_inc;
          did_d   = id_q;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      linea_q <= 1'b0;
      did_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      linea_q <= linea_d;
      did_q   <= did_d;
      res_q   <= res_d;
    end
  end

  // Grant is gated by reset so it drops the moment reset rises.
  always_comb begin
    bus.gnt = '0;
    if (state_q == S_IDLE && !reset && any) begin
      bus.gnt = NREQ'(1) << win;
    end
  end

  assign bus.LINEA   = linea_q;
  assign bus.done    = (state_q == S_DONE);
  assign bus.done_id = did_q;
  assign bus.result  = res_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule
